// File: rtl/count_capture_pkg.sv
// Shared types and default sizing for the counter snapshot/serialiser block.
package count_capture_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/count_fifo.sv
// Snapshot FIFO with first-word fall-through read; write and read may share an edge when full.
module count_fifo
    import count_capture_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_rd;
    logic             w_wr;

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_rd = rd_en && (r_level != '0);
    assign w_wr = wr_en && ((r_level != LW'(DEPTH)) || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + LW'(w_wr) - LW'(w_rd);
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;

endmodule

// File: rtl/count_capture.sv
// Captures counter snapshots into a FIFO and streams each word out MSB first over a valid/ready bit link.
module count_capture
    import count_capture_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     capture,
    input  logic                     ser_ready,
    output logic                     ser_valid,
    output logic                     ser_data,
    output logic                     ser_last,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_ovf;
    logic             w_pop;
    logic             w_wr;
    logic             w_full;
    logic             w_drop;
    logic [WIDTH-1:0] w_head;
    logic [LW-1:0]    w_level;

    count_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr),
        .wr_data (count_in),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .level   (w_level)
    );

    assign w_full = (w_level == LW'(DEPTH));
    assign w_wr   = capture && (!w_full || w_pop);
    assign w_drop = capture && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next values of the registered serial outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                if (w_level != '0) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_cnt_nxt   = CW'(WIDTH - 1);
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (WIDTH == 1);
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_valid && ser_ready) begin
                    w_shift_nxt = r_shift << 1;
                    if (r_cnt == '0) begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt  = r_cnt - CW'(1);
                        w_last_nxt = (r_cnt == CW'(1));
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Sticky drop flag; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign ser_valid  = r_valid;
    assign ser_data   = r_shift[WIDTH-1];
    assign ser_last   = r_last;
    assign fifo_level = w_level;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture: vector table for queueing/overflow plus hand sequences for streaming and reset.
module tb_count_capture;

    logic        clk;
    logic        reset;
    logic [31:0] count_in;
    logic        capture;
    logic        ser_ready;
    logic        ser_valid;
    logic        ser_data;
    logic        ser_last;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        clr_ovf;

    int n_vec = 0;
    int n_err = 0;

    count_capture #(.WIDTH(32), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .capture    (capture),
        .ser_ready  (ser_ready),
        .ser_valid  (ser_valid),
        .ser_data   (ser_data),
        .ser_last   (ser_last),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cap;
        logic [31:0] cin;
        logic        rdy;
        logic        clr;
        logic        e_valid;
        logic        e_data;
        logic        e_last;
        logic [2:0]  e_level;
        logic        e_ovf;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input logic d, input logic l,
                              input logic [2:0] lv, input logic o);
        check({tag, ".valid"}, 32'(ser_valid), 32'(v));
        check({tag, ".data"}, 32'(ser_data), 32'(d));
        check({tag, ".last"}, 32'(ser_last), 32'(l));
        check({tag, ".level"}, 32'(fifo_level), 32'(lv));
        check({tag, ".ovf"}, 32'(overflow), 32'(o));
    endtask

    // Collect one word; bad counts misplaced ser_last and bits not held while stalled.
    task automatic recv_word(input bit toggle, output logic [31:0] w, output int nx, output int bad);
        logic pd;
        logic pl;
        w   = '0;
        nx  = 0;
        bad = 0;
        capture = 1'b0;
        for (int cyc = 0; cyc < 300 && nx < 32; cyc++) begin
            ser_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            count_in  = $urandom;
            if (ser_valid && ser_ready) begin
                w = {w[30:0], ser_data};
                nx++;
                if (ser_last !== (nx == 32)) bad++;
                tick();
            end else if (ser_valid) begin
                pd = ser_data;
                pl = ser_last;
                tick();
                if (!ser_valid || ser_data !== pd || ser_last !== pl) bad++;
            end else begin
                tick();
            end
        end
    endtask

    task automatic expect_word(input string tag, input bit toggle, input logic [31:0] exp);
        logic [31:0] w;
        int nx;
        int bad;
        recv_word(toggle, w, nx, bad);
        check({tag, ".word"}, w, exp);
        check({tag, ".xfers"}, 32'(nx), 32'd32);
        check({tag, ".protocol"}, 32'(bad), 32'd0);
        check({tag, ".gap_valid"}, 32'(ser_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        count_in  = '0;
        capture   = 1'b0;
        ser_ready = 1'b0;
        clr_ovf   = 1'b0;

        tbl[0] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[1] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[2] = '{1'b1, 32'h1,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0};
        tbl[3] = '{1'b1, 32'h2,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0};
        tbl[4] = '{1'b1, 32'h3,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0};
        tbl[5] = '{1'b1, 32'h4,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0};
        tbl[6] = '{1'b1, 32'h5,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1};
        tbl[7] = '{1'b1, 32'h6,         1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1};
        tbl[8] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0};
        tbl[9] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0};

        // Held in reset across edges, with a capture request that must be ignored.
        capture  = 1'b1;
        count_in = 32'h1234_5678;
        tick();
        tick();
        check_outs("rst", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Capture on the first edge after release; valid two edges after the request.
        reset     = 1'b0;
        capture   = 1'b1;
        count_in  = 32'hA5A5_0F0F;
        ser_ready = 1'b1;
        tick();
        capture = 1'b0;
        check_outs("a5_edge1", 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
        tick();
        check_outs("a5_edge2", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        expect_word("a5", 1'b0, 32'hA5A5_0F0F);

        // Alternating ready stalls every other bit.
        capture  = 1'b1;
        count_in = 32'h8000_0001;
        tick();
        capture = 1'b0;
        expect_word("toggle", 1'b1, 32'h8000_0001);
        check("toggle.level", 32'(fifo_level), 32'd0);

        // Fill behind a stalled word, overflow, and clear priority.
        for (int i = 0; i < 10; i++) begin
            capture   = tbl[i].cap;
            count_in  = tbl[i].cin;
            ser_ready = tbl[i].rdy;
            clr_ovf   = tbl[i].clr;
            tick();
            check_outs($sformatf("tbl%0d", i), tbl[i].e_valid, tbl[i].e_data,
                       tbl[i].e_last, tbl[i].e_level, tbl[i].e_ovf);
        end
        capture = 1'b0;
        clr_ovf = 1'b0;

        // Drain the stalled word, then capture into a full FIFO on the pop edge.
        expect_word("beef", 1'b0, 32'hDEAD_BEEF);
        check("beef.level", 32'(fifo_level), 32'd4);
        capture  = 1'b1;
        count_in = 32'h7;
        tick();
        capture = 1'b0;
        check_outs("fullpop", 1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
        expect_word("q1", 1'b0, 32'h1);
        expect_word("q2", 1'b0, 32'h2);
        expect_word("q3", 1'b0, 32'h3);
        expect_word("q4", 1'b0, 32'h4);
        expect_word("q7", 1'b0, 32'h7);
        check("drain.level", 32'(fifo_level), 32'd0);

        // Reset mid-word with two snapshots queued.
        ser_ready = 1'b0;
        capture   = 1'b1;
        count_in  = 32'hFFFF_0000;
        tick();
        count_in = 32'h0000_FFFF;
        tick();
        count_in = 32'h5555_AAAA;
        tick();
        capture   = 1'b0;
        ser_ready = 1'b1;
        check("mid.level", 32'(fifo_level), 32'd2);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        check_outs("rst_hold", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        reset    = 1'b0;
        capture  = 1'b1;
        count_in = 32'hFFFF_FFFF;
        tick();
        capture = 1'b0;
        check("post_rst.level", 32'(fifo_level), 32'd1);
        expect_word("ones", 1'b0, 32'hFFFF_FFFF);
        tick();
        tick();
        check_outs("final", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/count_capture.md
COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 Parameter WIDTH, default 32, width of the captured count word (matches the 32-bit concatenated counter output).
REQ-002 Parameter DEPTH, default 4, snapshot FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all logic SHALL run on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 count_in  input  WIDTH  live counter word from the counter top level.
REQ-006 capture  input  1  snapshot request, sampled each clk edge.
REQ-007 ser_ready  input  1  downstream accepts the current serial bit.
REQ-008 ser_valid  output  1  ser_data holds a valid bit.
REQ-009 ser_data  output  1  serial bit, MSB first.
REQ-010 ser_last  output  1  high with the LSB (final bit) of a word.
REQ-011 fifo_level  output  $clog2(DEPTH)+1  number of stored snapshots.
REQ-012 overflow  output  1  sticky; a capture was dropped.
REQ-013 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-014 Capture: at an edge with capture=1, count_in SHALL be written to the FIFO if it is not full, or if a pop occurs on the same edge.
REQ-015 Capture with FIFO full and no same-edge pop: word dropped, overflow set at that edge, FIFO contents unchanged.
REQ-016 clr_ovf=1 clears overflow; simultaneous clr_ovf and dropped capture SHALL leave overflow=1 (set wins).
REQ-017 FSM states IDLE, SHIFT.
REQ-018 IDLE: ser_valid=0; if FIFO non-empty, pop head into shift register, load bit counter with WIDTH-1, go to SHIFT.
REQ-019 Latency: capture at edge k into an empty FIFO with FSM in IDLE -> ser_valid=1 after edge k+1, with ser_data = bit WIDTH-1 of the captured word.
REQ-020 SHIFT: ser_valid=1; ser_data = shift register MSB; ser_last=1 when bit counter = 0.
REQ-021 Handshake: a bit transfers only at an edge with ser_valid=1 and ser_ready=1; otherwise ser_data and ser_last SHALL hold.
REQ-022 On a transfer with bit counter > 0: shift left by one and decrement the counter.
REQ-023 On a transfer with ser_last=1: return to IDLE; one ser_valid=0 cycle SHALL separate consecutive words.
REQ-024 fifo_level SHALL equal writes minus pops and never exceed DEPTH; a same-edge write and pop leaves it unchanged.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; full = (level = DEPTH), empty = (level = 0).
REQ-026 count_in is sampled only at the capture edge; later changes SHALL NOT affect the stored word.

Reset
REQ-027 While reset=1: FSM=IDLE, FIFO empty, fifo_level=0, ser_valid=0, ser_data=0, ser_last=0, overflow=0, shift register and bit counter=0.
REQ-028 Reset asserted mid-word SHALL abort the word immediately; stored snapshots are discarded.
REQ-029 A capture on the first edge after reset deassertion SHALL be accepted.

Structure
REQ-030 Package count_capture_pkg SHALL hold the FSM state enum and the default WIDTH and DEPTH constants.
REQ-031 The FIFO SHALL be a sub-module count_fifo (clk, reset, wr_en, wr_data, rd_en, rd_data, level), with first-word fall-through read.

Verification
REQ-032 Reset, capture count_in=0xA5A5_0F0F, ser_ready=1 -> ser_valid rises 2 edges later; 32 bits 1,0,1,0,0,1,0,1,... are sent; ser_last is high on bit 32 only; then ser_valid=0.
REQ-033 ser_ready toggled 1/0 on alternate cycles during word 0x8000_0001 -> each bit is held while ser_ready=0; exactly 32 transfers; first and last bits are 1.
REQ-034 ser_ready=0, five captures of 1..5 -> fifo_level reaches 4, overflow=1 after the 5th; release ser_ready -> words 1,2,3,4 are sent in order.
REQ-035 FIFO full, capture on the same edge as the IDLE pop -> write accepted, fifo_level stays 4, overflow stays 0.
REQ-036 Reset asserted at bit 10 of a word with 2 words queued -> next cycle all outputs = 0, fifo_level=0; a new capture of 0xFFFF_FFFF is then sent intact.
REQ-037 clr_ovf asserted together with a dropped capture -> overflow remains 1; clr_ovf alone on the next edge -> overflow=0.
